// File: rtl/pci_target_seq.sv
// pci_target_seq: PCI target bus sequencer, latches the address phase, emits
// decode strobes for pci_cfg_space and drives DEVSEL#/TRDY#/STOP#.
module pci_target_seq #(
  parameter int INIT_LAT = 16,
  parameter int LAT_W    = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_n,
  input  logic        irdy_n,
  input  logic        idsel,
  input  logic [3:0]  cbe_n,
  input  logic [31:0] adi,
  input  logic        card_hit,
  input  logic        cfg_drdy,
  input  logic        usr_drdy,
  input  logic        t_abort,
  output logic [5:0]  adr,
  output logic [3:0]  cbeid,
  output logic        cmd_cfgrd,
  output logic        cmd_cfgwr,
  output logic        acc_cfg,
  output logic        acc_io,
  output logic        acc_mem,
  output logic        first_cyc,
  output logic        acc_end,
  output logic        cfg_sent,
  output logic        devsel_n,
  output logic        trdy_n,
  output logic        stop_n,
  output logic        ctl_oe
);
  localparam logic [2:0] IDLE = 3'd0, DECODE = 3'd1, DATA = 3'd2, STOPPING = 3'd3, TURN = 3'd4, WAIT_IDLE = 3'd5;
  logic [2:0] state;
  logic frame_q;
  logic [LAT_W-1:0] lat;
  logic is_cfg, is_io, is_mem, addr_ph, claim, ready, xfer, trdy_nx, disc, retry, to_turn, clr;
  logic [5:0] adr_nx;
  logic unused_adi;
  assign unused_adi = ^adi[31:8];
  assign is_cfg  = idsel && adi[1:0] == 2'b00 && cbe_n[3:1] == 3'b101;
  assign is_io   = cbe_n[3:1] == 3'b001;
  assign is_mem  = cbe_n[3:1] == 3'b011 || cbe_n == 4'b1100 || cbe_n[3:1] == 3'b111;
  assign addr_ph = state == IDLE && !frame_n && frame_q && (is_cfg || is_io || is_mem);
  assign claim   = acc_cfg || ((acc_io || acc_mem) && card_hit);
  assign ready   = acc_cfg ? cfg_drdy : usr_drdy;
  assign xfer    = !irdy_n && !trdy_n;
  assign adr_nx  = adr + 6'(xfer && acc_mem);
  assign trdy_nx = (trdy_n || xfer) ? !ready : 1'b0;
  // disconnect with data: single-phase accesses, or the burst phase that would wrap
  assign disc    = !trdy_nx && !frame_n && (!acc_mem || adr_nx == 6'd63);
  assign retry   = lat == LAT_W'(INIT_LAT - 1) && trdy_n && !ready;
  assign to_turn = (state == DATA && !t_abort && xfer && frame_n) || (state == STOPPING && frame_n && !irdy_n);
  assign clr     = to_turn || (state == DECODE && !claim);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      frame_q <= 1'b1;
      lat <= '0;
      adr <= '0;
      cbeid <= '0;
      {acc_cfg, acc_io, acc_mem, cmd_cfgrd, cmd_cfgwr} <= '0;
      {first_cyc, acc_end, cfg_sent} <= '0;
      {devsel_n, trdy_n, stop_n} <= '1;
      ctl_oe <= 1'b0;
    end else begin
      frame_q <= frame_n;
      first_cyc <= addr_ph;
      acc_end <= to_turn;
      cfg_sent <= state == DATA && xfer && acc_cfg;
      case (state)
        IDLE: if (addr_ph) begin
          adr <= adi[7:2];
          acc_cfg <= is_cfg;
          acc_io <= is_io;
          acc_mem <= is_mem;
          cmd_cfgrd <= is_cfg && !cbe_n[0];
          cmd_cfgwr <= is_cfg && cbe_n[0];
          lat <= '0;
          state <= DECODE;
        end
        DECODE: begin
          lat <= lat + 1'b1;
          devsel_n <= !claim;
          ctl_oe <= claim;
          state <= claim ? DATA : WAIT_IDLE;
        end
        DATA: begin
          cbeid <= ~cbe_n;
          adr <= adr_nx;
          lat <= xfer ? '0 : lat + 1'b1;
          if (t_abort) begin
            devsel_n <= 1'b1;
            trdy_n <= 1'b1;
            stop_n <= 1'b0;
            state <= STOPPING;
          end else if ((xfer && !stop_n) || retry) begin
            trdy_n <= 1'b1;
            stop_n <= 1'b0;
            state <= STOPPING;
          end else begin
            trdy_n <= trdy_nx;
            stop_n <= !disc;
          end
        end
        STOPPING: ;
        TURN: begin
          ctl_oe <= 1'b0;
          state <= IDLE;
        end
        WAIT_IDLE: if (frame_n && irdy_n) state <= IDLE;
        default: state <= IDLE;
      endcase
      if (to_turn) begin
        {devsel_n, trdy_n, stop_n} <= '1;
        state <= TURN;
      end
      if (clr) {acc_cfg, acc_io, acc_mem, cmd_cfgrd, cmd_cfgwr} <= '0;
    end
  end
endmodule
